// File: rtl/read_dispatch_pkg.sv
// Shared constants and grant-selection helpers for the read dispatcher.
// Helpers work on 32-bit request vectors; callers zero-extend narrower channel counts.
package read_dispatch_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;
    localparam int unsigned CH_MAX     = 32;

    // Isolate the lowest set bit.
    function automatic logic [CH_MAX-1:0] prio_lsb(input logic [CH_MAX-1:0] req);
        return req & (~req + 32'd1);
    endfunction

    // First requester strictly above 'last', otherwise wrap to the lowest requester.
    function automatic logic [CH_MAX-1:0] rr_pick(input logic [CH_MAX-1:0] req,
                                                 input logic [4:0]         last);
        logic [CH_MAX-1:0] mask_hi;
        mask_hi = ~((32'd2 << last) - 32'd1);
        if (|(req & mask_hi))
            return prio_lsb(req & mask_hi);
        return prio_lsb(req);
    endfunction

    function automatic logic [4:0] onehot2idx(input logic [CH_MAX-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < CH_MAX; i++) begin
            if (oh[i[4:0]])
                idx |= i[4:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/read_dispatch_fifo.sv
// Synchronous input FIFO for the read dispatcher: registered full/empty, no fall-through.
// Storage is cleared on reset so the head reads as zero when idle.
module read_dispatch_fifo #(
    parameter int unsigned DW    = 512,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic          multi
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is refused even when a pop frees a slot this cycle.
    always_comb begin
        do_push   = push & ~full;
        do_pop    = pop & ~empty;
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_comb begin
        head  = mem[rd_ptr];
        multi = (count > CW'(1));
    end

endmodule

// File: rtl/read_dispatch_rr.sv
// Read dispatcher: input FIFO fanned out to CH channels via a sticky one-hot grant.
// Optional per-channel accept counters when READ_DISPATCH_STAT_EN is defined.
module read_dispatch_rr
    import read_dispatch_pkg::*;
#(
    parameter int unsigned CH    = 16,
    parameter int unsigned DW    = 512,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned MODE  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          ri_data,
    input  logic                   ri_valid,
    output logic                   ri_ready,
    output logic [CH-1:0][DW-1:0]  ro_data,
    output logic [CH-1:0]          ro_valid,
    input  logic [CH-1:0]          ro_ready
`ifdef READ_DISPATCH_STAT_EN
    ,
    input  logic                   stat_clr,
    output logic [CH-1:0][31:0]    stat_cnt
`endif
);

    logic [CH-1:0] gnt;
    logic [CH-1:0] gnt_nxt;
    logic [CH-1:0] pick;
    logic [CH-1:0] hs_vec;
    logic [4:0]    last;
    logic [4:0]    last_eff;
    logic          hs;
    logic [DW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_multi;

    read_dispatch_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ri_valid),
        .push_data (ri_data),
        .pop       (hs),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .multi     (fifo_multi)
    );

    // The next pick already sees the channel being accepted this cycle as 'last',
    // which is what lets round-robin advance back-to-back without a bubble.
    always_comb begin
        hs_vec   = gnt & ro_ready;
        hs       = |hs_vec;
        last_eff = hs ? onehot2idx(32'(gnt)) : last;
        if (MODE == MODE_FIXED)
            pick = CH'(prio_lsb(32'(ro_ready)));
        else
            pick = CH'(rr_pick(32'(ro_ready), last_eff));

        gnt_nxt = gnt;
        if (hs)
            gnt_nxt = fifo_multi ? pick : '0;
        else if ((gnt == '0) && !fifo_empty)
            gnt_nxt = pick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt  <= '0;
            last <= 5'(CH - 1);
        end else begin
            gnt  <= gnt_nxt;
            last <= last_eff;
        end
    end

    always_comb begin
        ri_ready = ~fifo_full;
        ro_valid = gnt;
        ro_data  = {CH{head}};
    end

`ifdef READ_DISPATCH_STAT_EN
    for (genvar g = 0; g < CH; g++) begin : g_stat
        always_ff @(posedge clk) begin
            if (rst || stat_clr)
                stat_cnt[g] <= '0;
            else if (hs_vec[g])
                stat_cnt[g] <= stat_cnt[g] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_read_dispatch_rr.sv
// Directed bench for read_dispatch_rr: one round-robin and one fixed-priority instance.
// Stat counter checks are included when READ_DISPATCH_STAT_EN is defined.
module tb_read_dispatch_rr;

    localparam int unsigned CH    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [DW-1:0]         rr_ri_data  = '0;
    logic                  rr_ri_valid = 1'b0;
    logic                  rr_ri_ready;
    logic [CH-1:0][DW-1:0] rr_ro_data;
    logic [CH-1:0]         rr_ro_valid;
    logic [CH-1:0]         rr_ro_ready = '0;

    logic [DW-1:0]         fx_ri_data  = '0;
    logic                  fx_ri_valid = 1'b0;
    logic                  fx_ri_ready;
    logic [CH-1:0][DW-1:0] fx_ro_data;
    logic [CH-1:0]         fx_ro_valid;
    logic [CH-1:0]         fx_ro_ready = '0;

`ifdef READ_DISPATCH_STAT_EN
    logic                  rr_stat_clr = 1'b0;
    logic                  fx_stat_clr = 1'b0;
    logic [CH-1:0][31:0]   rr_stat_cnt;
    logic [CH-1:0][31:0]   fx_stat_cnt;
`endif

    int vectors = 0;
    int errs    = 0;

    read_dispatch_rr #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .MODE(1)) dut_rr (
        .clk      (clk),
        .rst      (rst),
        .ri_data  (rr_ri_data),
        .ri_valid (rr_ri_valid),
        .ri_ready (rr_ri_ready),
        .ro_data  (rr_ro_data),
        .ro_valid (rr_ro_valid),
        .ro_ready (rr_ro_ready)
`ifdef READ_DISPATCH_STAT_EN
        ,
        .stat_clr (rr_stat_clr),
        .stat_cnt (rr_stat_cnt)
`endif
    );

    read_dispatch_rr #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .MODE(0)) dut_fx (
        .clk      (clk),
        .rst      (rst),
        .ri_data  (fx_ri_data),
        .ri_valid (fx_ri_valid),
        .ri_ready (fx_ri_ready),
        .ro_data  (fx_ro_data),
        .ro_valid (fx_ro_valid),
        .ro_ready (fx_ro_ready)
`ifdef READ_DISPATCH_STAT_EN
        ,
        .stat_clr (fx_stat_clr),
        .stat_cnt (fx_stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(rr_ro_valid), 64'h0);
        chk("rst_ready", 64'(rr_ri_ready), 64'h1);
        chk("rst_data", 64'(rr_ro_data[0]), 64'h0);
`ifdef READ_DISPATCH_STAT_EN
        chk("rst_stat", 64'(rr_stat_cnt[0]), 64'h0);
`endif
        rst = 1'b0;

        // Single read, all ready
        rr_ro_ready = '1;
        rr_ri_data  = 32'hA5;
        rr_ri_valid = 1'b1;
        step();
        rr_ri_valid = 1'b0;
        chk("single_no_bypass", 64'(rr_ro_valid), 64'h0);
        step();
        chk("single_grant", 64'(rr_ro_valid), 64'h1);
        chk("single_data", 64'(rr_ro_data[0]), 64'hA5);
        step();
        chk("single_done_valid", 64'(rr_ro_valid), 64'h0);
        chk("single_done_ready", 64'(rr_ri_ready), 64'h1);
`ifdef READ_DISPATCH_STAT_EN
        chk("single_stat0", 64'(rr_stat_cnt[0]), 64'h1);
`endif

        // Round-robin, 20 back-to-back reads
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 22; k++) begin
            if (k < 20) begin
                rr_ri_valid = 1'b1;
                rr_ri_data  = 32'h100 + k;
            end else begin
                rr_ri_valid = 1'b0;
            end
            step();
            if (k >= 1 && k <= 20) begin
                chk("rr_grant", 64'(rr_ro_valid), 64'h1 << ((k - 1) % 16));
                chk("rr_data", 64'(rr_ro_data[0]), 64'(32'h100 + k - 1));
            end
        end
        chk("rr_drain", 64'(rr_ro_valid), 64'h0);

        // Fixed priority with ready 0x0110, then only bit 8
        fx_ro_ready = 16'h0110;
        fx_ri_valid = 1'b1;
        fx_ri_data  = 32'h200;
        step();
        fx_ri_data  = 32'h201;
        step();
        fx_ri_valid = 1'b0;
        chk("fx_grant_a", 64'(fx_ro_valid), 64'h0010);
        chk("fx_data_a", 64'(fx_ro_data[4]), 64'h200);
        step();
        chk("fx_grant_b", 64'(fx_ro_valid), 64'h0010);
        chk("fx_data_b", 64'(fx_ro_data[4]), 64'h201);
        step();
        chk("fx_idle", 64'(fx_ro_valid), 64'h0);
        fx_ro_ready = 16'h0100;
        fx_ri_valid = 1'b1;
        fx_ri_data  = 32'h202;
        step();
        fx_ri_data  = 32'h203;
        step();
        fx_ri_valid = 1'b0;
        chk("fx_grant_c", 64'(fx_ro_valid), 64'h0100);
        chk("fx_data_c", 64'(fx_ro_data[8]), 64'h202);
        step();
        chk("fx_grant_d", 64'(fx_ro_valid), 64'h0100);
        chk("fx_data_d", 64'(fx_ro_data[8]), 64'h203);
        step();
        chk("fx_drain", 64'(fx_ro_valid), 64'h0);

        // Hold: grant on ch3 survives ready drop
        rst = 1'b1;
        step();
        rst = 1'b0;
        rr_ro_ready = 16'h0008;
        rr_ri_valid = 1'b1;
        rr_ri_data  = 32'h3C3;
        step();
        rr_ri_valid = 1'b0;
        step();
        chk("hold_grant", 64'(rr_ro_valid), 64'h0008);
        rr_ro_ready = 16'hFFF7;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_valid", 64'(rr_ro_valid), 64'h0008);
            chk("hold_data", 64'(rr_ro_data[3]), 64'h3C3);
        end
        rr_ro_ready = 16'hFFFF;
        step();
        chk("hold_accept", 64'(rr_ro_valid), 64'h0);
`ifdef READ_DISPATCH_STAT_EN
        chk("hold_stat3", 64'(rr_stat_cnt[3]), 64'h1);
        chk("hold_stat4", 64'(rr_stat_cnt[4]), 64'h0);
`endif
        rr_ri_valid = 1'b1;
        rr_ri_data  = 32'h444;
        step();
        rr_ri_valid = 1'b0;
        step();
        chk("hold_next_rr", 64'(rr_ro_valid), 64'h0010);
        step();

        // Backpressure: fill FIFO, then drain through ch7
        rst = 1'b1;
        step();
        rst = 1'b0;
        rr_ro_ready = '0;
        for (int k = 0; k < 4; k++) begin
            chk("bp_open", 64'(rr_ri_ready), 64'h1);
            rr_ri_valid = 1'b1;
            rr_ri_data  = 32'h500 + k;
            step();
        end
        chk("bp_full", 64'(rr_ri_ready), 64'h0);
        chk("bp_no_grant", 64'(rr_ro_valid), 64'h0);
        rr_ri_data = 32'h504;
        step();
        step();
        chk("bp_still_full", 64'(rr_ri_ready), 64'h0);
        rr_ro_ready = 16'h0080;
        step();
        chk("bp_grant0", 64'(rr_ro_valid), 64'h0080);
        chk("bp_data0", 64'(rr_ro_data[7]), 64'h500);
        chk("bp_full_pop", 64'(rr_ri_ready), 64'h0);
        step();
        chk("bp_data1", 64'(rr_ro_data[7]), 64'h501);
        chk("bp_reopen", 64'(rr_ri_ready), 64'h1);
        step();
        rr_ri_valid = 1'b0;
        chk("bp_data2", 64'(rr_ro_data[7]), 64'h502);
        step();
        chk("bp_data3", 64'(rr_ro_data[7]), 64'h503);
        step();
        chk("bp_grant4", 64'(rr_ro_valid), 64'h0080);
        chk("bp_data4", 64'(rr_ro_data[7]), 64'h504);
        step();
        chk("bp_drain", 64'(rr_ro_valid), 64'h0);

        // Reset mid-flight with three entries and a pending grant
        rr_ro_ready = '0;
        for (int k = 0; k < 3; k++) begin
            rr_ri_valid = 1'b1;
            rr_ri_data  = 32'h600 + k;
            step();
        end
        rr_ri_valid = 1'b0;
        rr_ro_ready = 16'h0020;
        step();
        chk("mid_pending", 64'(rr_ro_valid), 64'h0020);
        rr_ro_ready = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(rr_ro_valid), 64'h0);
        chk("mid_rst_ready", 64'(rr_ri_ready), 64'h1);
        chk("mid_rst_data", 64'(rr_ro_data[0]), 64'h0);
`ifdef READ_DISPATCH_STAT_EN
        chk("mid_rst_stat", 64'(rr_stat_cnt[7]), 64'h0);
`endif
        rr_ro_ready = '1;
        rr_ri_valid = 1'b1;
        rr_ri_data  = 32'h6AA;
        step();
        rr_ri_valid = 1'b0;
        step();
        chk("post_rst_grant", 64'(rr_ro_valid), 64'h1);
        chk("post_rst_data", 64'(rr_ro_data[0]), 64'h6AA);
`ifdef READ_DISPATCH_STAT_EN
        rr_stat_clr = 1'b1;
`endif
        step();
        chk("post_rst_accept", 64'(rr_ro_valid), 64'h0);
`ifdef READ_DISPATCH_STAT_EN
        chk("stat_clr_prio", 64'(rr_stat_cnt[0]), 64'h0);
        rr_stat_clr = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
